reset_sequencer: RTL and testbench

Parametrised multi-channel reset controller that generates ordered, glitch-free resets for up to NUM_CH downstream blocks (processor core, memories, peripherals) from one board-level reset. Assertion is asynchronous. Release is synchronised, held for a programmable time, then staged channel by channel. It also supports software-requested re-sequencing and, optionally, a watchdog-triggered reset. It sits between the top-level reset pin and every block's active-high `reset` input.

---
 rtl/reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_reset_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: async assert, synchronised release, hold, then staged per-channel release.
// Optional watchdog-triggered re-sequencing is enabled by defining RSTSEQ_WDOG_EN.
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
`ifdef RSTSEQ_WDOG_EN
    ,
    parameter int WDOG_TIMEOUT = 1024
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic              done
`ifdef RSTSEQ_WDOG_EN
    ,
    input  logic              wdog_kick,
    output logic              wdog_fired
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_ASSERT  = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 2);

    logic              rs1;
    logic              rs2;
    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   ch_nx;
    logic [NUM_CH-1:0] rst_nx;
    logic              wdog_trip;
    logic              restart;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1 <= 1'b0;
            rs2 <= 1'b0;
        end else begin
            rs1 <= 1'b1;
            rs2 <= rs1;
        end
    end

    assign restart = sw_rst_req | wdog_trip;

    // A restart always wins, so no channel can fall on an edge that samples one.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ch_nx    = ch;
        rst_nx   = rst_out;
        if (restart) begin
            state_nx = S_ASSERT;
            cnt_nx   = '0;
            ch_nx    = '0;
            rst_nx   = '1;
        end else if (rs2) begin
            case (state)
                S_ASSERT: begin
                    rst_nx = '1;
                    if (cnt == HOLD_LAST) begin
                        cnt_nx   = '0;
                        ch_nx    = '0;
                        rst_nx   = {NUM_CH{1'b1}} << 1;
                        state_nx = (NUM_CH == 1) ? S_RUN : S_RELEASE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nx = '0;
                        ch_nx  = ch + 1'b1;
                        rst_nx = rst_out << 1;
                        if (ch == LAST_CH) begin
                            state_nx = S_RUN;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    rst_nx = '0;
                    cnt_nx = '0;
                end
                default: begin
                    state_nx = S_ASSERT;
                    cnt_nx   = '0;
                    ch_nx    = '0;
                    rst_nx   = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_ASSERT;
            cnt     <= '0;
            ch      <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ch      <= ch_nx;
            rst_out <= rst_nx;
            busy    <= (state_nx != S_RUN);
            done    <= (state_nx == S_RUN);
        end
    end

`ifdef RSTSEQ_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_TIMEOUT - 1);

    logic [15:0] wdog_cnt;

    // A kick on the timeout edge suppresses the trip.
    assign wdog_trip = (state == S_RUN) && !wdog_kick && (wdog_cnt == WDOG_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt   <= '0;
            wdog_fired <= 1'b0;
        end else begin
            if (state == S_RUN && state_nx == S_RUN && !wdog_kick) begin
                wdog_cnt <= wdog_cnt + 16'd1;
            end else begin
                wdog_cnt <= '0;
            end
            if (wdog_trip) begin
                wdog_fired <= 1'b1;
            end
        end
    end
`else
    assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a 4-channel and a 1-channel instance against a timing-formula model.
// Watchdog checks are included when RSTSEQ_WDOG_EN is defined.
module tb_reset_sequencer;

    localparam int HOLD_A = 16;
    localparam int GAP_A  = 8;
    localparam int HOLD_B = 1;
    localparam int GAP_B  = 8;
    localparam int WDOG_T = 20;

    logic       clk;
    logic       reset;
    logic       sw_rst_req;
    logic [3:0] rst_a;
    logic       busy_a;
    logic       done_a;
    logic [0:0] rst_b;
    logic       busy_b;
    logic       done_b;
`ifdef RSTSEQ_WDOG_EN
    logic       wdog_kick;
    logic       fired_a;
    logic       fired_b;
    logic       exp_fired;
    int         quiet;
`endif

    int checks;
    int errors;
    int edge_n;
    int start_a;
    int start_b;

    reset_sequencer #(
        .NUM_CH(4), .CNT_W(8), .HOLD_CYCLES(HOLD_A), .STAGE_GAP(GAP_A)
`ifdef RSTSEQ_WDOG_EN
        , .WDOG_TIMEOUT(WDOG_T)
`endif
    ) dut_a (
        .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
        .rst_out(rst_a), .busy(busy_a), .done(done_a)
`ifdef RSTSEQ_WDOG_EN
        , .wdog_kick(wdog_kick), .wdog_fired(fired_a)
`endif
    );

    reset_sequencer #(
        .NUM_CH(1), .CNT_W(8), .HOLD_CYCLES(HOLD_B), .STAGE_GAP(GAP_B)
`ifdef RSTSEQ_WDOG_EN
        , .WDOG_TIMEOUT(WDOG_T)
`endif
    ) dut_b (
        .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
        .rst_out(rst_b), .busy(busy_b), .done(done_b)
`ifdef RSTSEQ_WDOG_EN
        , .wdog_kick(1'b1), .wdog_fired(fired_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel k is released at edge start + hold + k*gap, where start is the last restart edge.
    function automatic logic [31:0] expRst(input int n, input int start, input int nch, input int hold, input int gap);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < nch; k++) begin
            v[k] = (n < start + hold + k * gap);
        end
        return v;
    endfunction

    function automatic logic expDone(input int n, input int start, input int nch, input int hold, input int gap);
        return (n >= start + hold + (nch - 1) * gap);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic checkAll();
        logic da;
        logic db;
        da = expDone(edge_n, start_a, 4, HOLD_A, GAP_A);
        db = expDone(edge_n, start_b, 1, HOLD_B, GAP_B);
        checkOutput("rst_a", 32'(rst_a), expRst(edge_n, start_a, 4, HOLD_A, GAP_A));
        checkOutput("done_a", 32'(done_a), 32'(da));
        checkOutput("busy_a", 32'(busy_a), 32'(!da));
        checkOutput("rst_b", 32'(rst_b), expRst(edge_n, start_b, 1, HOLD_B, GAP_B));
        checkOutput("done_b", 32'(done_b), 32'(db));
        checkOutput("busy_b", 32'(busy_b), 32'(!db));
`ifdef RSTSEQ_WDOG_EN
        checkOutput("fired_a", 32'(fired_a), 32'(exp_fired));
        checkOutput("fired_b", 32'(fired_b), 32'd0);
`endif
    endtask

    // Async reset asserted mid-cycle; outputs must change before the next clock edge.
    task automatic doReset(input int cycles);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_rst_a", 32'(rst_a), 32'hF);
        checkOutput("async_busy_a", 32'(busy_a), 32'd1);
        checkOutput("async_done_a", 32'(done_a), 32'd0);
        checkOutput("async_rst_b", 32'(rst_b), 32'h1);
        repeat (cycles) begin
            @(negedge clk);
            checkOutput("hold_rst_a", 32'(rst_a), 32'hF);
            checkOutput("hold_done_a", 32'(done_a), 32'd0);
`ifdef RSTSEQ_WDOG_EN
            checkOutput("hold_fired_a", 32'(fired_a), 32'd0);
`endif
        end
        reset   = 1'b1;
        edge_n  = 0;
        start_a = 2;
        start_b = 2;
`ifdef RSTSEQ_WDOG_EN
        quiet     = 0;
        exp_fired = 1'b0;
`endif
    endtask

    // One clock: drive sw_rst_req (and the kick already set by the caller), advance the model, check.
    task automatic applyStimulus(input logic sw);
        logic trip;
`ifdef RSTSEQ_WDOG_EN
        logic was_run;
        was_run = expDone(edge_n, start_a, 4, HOLD_A, GAP_A);
`endif
        sw_rst_req = sw;
        @(posedge clk);
        edge_n++;
        trip = 1'b0;
`ifdef RSTSEQ_WDOG_EN
        if (was_run) begin
            if (wdog_kick) quiet = 0;
            else quiet++;
            trip = (quiet == WDOG_T);
        end else begin
            quiet = 0;
        end
        if (trip) exp_fired = 1'b1;
        if (sw || trip) quiet = 0;
`endif
        if ((sw || trip) && edge_n > start_a) start_a = edge_n;
        if (sw && edge_n > start_b) start_b = edge_n;
        @(negedge clk);
        sw_rst_req = 1'b0;
`ifdef RSTSEQ_WDOG_EN
        wdog_kick = 1'b0;
`endif
        checkAll();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        edge_n     = 0;
        start_a    = 2;
        start_b    = 2;
        reset      = 1'b1;
        sw_rst_req = 1'b0;
`ifdef RSTSEQ_WDOG_EN
        wdog_kick = 1'b0;
        quiet     = 0;
        exp_fired = 1'b0;
`endif

        $display("[TB] power-on sequence");
        doReset(3);
        repeat (50) applyStimulus(1'b0);

        $display("[TB] software request in RUN");
        applyStimulus(1'b1);
        repeat (48) applyStimulus(1'b0);

        $display("[TB] request colliding with channel 2 release");
        applyStimulus(1'b1);
        for (int i = 0; i < 100 && (edge_n + 1) < start_a + HOLD_A + 2 * GAP_A; i++) begin
            applyStimulus(1'b0);
        end
        applyStimulus(1'b1);
        checkOutput("collision_rst_a", 32'(rst_a), 32'hF);
        repeat (48) applyStimulus(1'b0);

        $display("[TB] reset between E26 and E27");
        doReset(1);
        for (int i = 0; i < 100 && edge_n < 26; i++) begin
            applyStimulus(1'b0);
        end
        doReset(2);
        repeat (48) applyStimulus(1'b0);

`ifdef RSTSEQ_WDOG_EN
        $display("[TB] watchdog: regular kicks then silence");
        for (int i = 0; i < 120; i++) begin
            wdog_kick = (i % 10 == 0);
            applyStimulus(1'b0);
        end
        repeat (70) applyStimulus(1'b0);
        checkOutput("wdog_fired_after_silence", 32'(fired_a), 32'd1);
`endif

        $display("[TB] randomized phase");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset(int'($urandom_range(1, 3)));
            end else begin
`ifdef RSTSEQ_WDOG_EN
                wdog_kick = ($urandom_range(0, 24) == 0);
`endif
                applyStimulus($urandom_range(0, 119) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
